// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forward controller.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  // Register IDs are zero-extended into a fixed-width field so the struct stays package-level.
  localparam int SB_DST_W = 8;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic [SB_DST_W-1:0] dst;
    logic                is_load;
  } sb_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage, memory handshake and pipeline-control bundle between the CPU and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ID_W = 4,
  parameter int NUM_SRC  = 2
);
  logic                         id_valid;
  logic [NUM_SRC*REG_ID_W-1:0]  id_src_id;
  logic [NUM_SRC-1:0]           id_src_used;
  logic [REG_ID_W-1:0]          id_dst_id;
  logic                         id_dst_wr;
  logic                         id_is_load;
  logic                         redirect;
  logic                         mem_req;
  logic                         mem_ready;

  logic                         pipe_en;
  logic                         pc_write;
  logic                         ifid_write;
  logic                         ifid_flush;
  logic                         idex_bubble;
  logic [NUM_SRC*2-1:0]         fwd_sel;
  logic                         mem_timeout;
  logic [15:0]                  stall_cycles;
  logic [15:0]                  flush_cycles;
  logic [15:0]                  freeze_cycles;

  modport master (
    output id_valid, id_src_id, id_src_used, id_dst_id, id_dst_wr, id_is_load,
           redirect, mem_req, mem_ready,
    input  pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, fwd_sel,
           mem_timeout, stall_cycles, flush_cycles, freeze_cycles
  );

  modport slave (
    input  id_valid, id_src_id, id_src_used, id_dst_id, id_dst_wr, id_is_load,
           redirect, mem_req, mem_ready,
    output pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, fwd_sel,
           mem_timeout, stall_cycles, flush_cycles, freeze_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// EX/MEM/WB destination scoreboard plus the EX-stage source-operand latch.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_ID_W = 4,
  parameter int NUM_SRC  = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        advance_i,
  input  logic                        bubble_i,
  input  sb_entry_t                   id_entry_i,
  input  logic [NUM_SRC*REG_ID_W-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]          id_used_i,
  output sb_entry_t [SB_DEPTH-1:0]    sb_o,
  output logic [NUM_SRC*REG_ID_W-1:0] ex_src_o,
  output logic [NUM_SRC-1:0]          ex_used_o
);

  sb_entry_t [SB_DEPTH-1:0]    sb_q;
  logic [NUM_SRC*REG_ID_W-1:0] ex_src_q;
  logic [NUM_SRC-1:0]          ex_used_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sb_q      <= '0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
    end else if (advance_i) begin
      sb_q[SB_WB]  <= sb_q[SB_MEM];
      sb_q[SB_MEM] <= sb_q[SB_EX];
      if (bubble_i) begin
        sb_q[SB_EX] <= '0;
        ex_src_q    <= '0;
        ex_used_q   <= '0;
      end else begin
        sb_q[SB_EX] <= id_entry_i;
        ex_src_q    <= id_src_i;
        ex_used_q   <= id_used_i;
      end
    end
  end

  assign sb_o      = sb_q;
  assign ex_src_o  = ex_src_q;
  assign ex_used_o = ex_used_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-freeze controller for the 5-stage pipeline.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ID_W    = 4,
  parameter int NUM_SRC     = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);

  sb_entry_t [SB_DEPTH-1:0]    sb;
  sb_entry_t                   id_entry;
  logic [NUM_SRC*REG_ID_W-1:0] ex_src;
  logic [NUM_SRC-1:0]          ex_used;
  logic                        freeze, loaduse, src_hit;
  logic                        redirect_act, loaduse_act;
  logic [NUM_SRC*2-1:0]        fwd_sel_d;
  logic [15:0]                 wait_q, wait_d;
  logic                        timeout_q, timeout_d;
  logic                        unused_sb;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = bus.id_valid;
    id_entry.wr      = bus.id_dst_wr;
    id_entry.dst     = SB_DST_W'(bus.id_dst_id);
    id_entry.is_load = bus.id_is_load;
  end

  hazard_scoreboard #(.REG_ID_W(REG_ID_W), .NUM_SRC(NUM_SRC)) u_sb (
    .CLK        (CLK),
    .RST        (RST),
    .advance_i  (bus.pipe_en),
    .bubble_i   (bus.idex_bubble),
    .id_entry_i (id_entry),
    .id_src_i   (bus.id_src_id),
    .id_used_i  (bus.id_src_used),
    .sb_o       (sb),
    .ex_src_o   (ex_src),
    .ex_used_o  (ex_used)
  );

  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.id_src_used[k] &&
          SB_DST_W'(bus.id_src_id[k*REG_ID_W +: REG_ID_W]) == sb[SB_EX].dst)
        src_hit = 1'b1;
    end
  end

  assign freeze       = bus.mem_req & ~bus.mem_ready;
  assign loaduse      = bus.id_valid & sb[SB_EX].valid & sb[SB_EX].wr & sb[SB_EX].is_load & src_hit;
  assign redirect_act = ~freeze & bus.redirect;
  assign loaduse_act  = ~freeze & ~bus.redirect & loaduse;

  assign bus.pipe_en     = ~freeze;
  assign bus.pc_write    = ~freeze & ~loaduse_act;
  assign bus.ifid_write  = ~freeze & ~loaduse_act;
  assign bus.ifid_flush  = redirect_act;
  assign bus.idex_bubble = redirect_act | loaduse_act;

  // MEM-stage match is checked first so the younger writer wins.
  always_comb begin
    fwd_sel_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_used[k]) begin
        if (sb[SB_MEM].valid && sb[SB_MEM].wr &&
            sb[SB_MEM].dst == SB_DST_W'(ex_src[k*REG_ID_W +: REG_ID_W]))
          fwd_sel_d[k*2 +: 2] = FWD_MEM;
        else if (sb[SB_WB].valid && sb[SB_WB].wr &&
                 sb[SB_WB].dst == SB_DST_W'(ex_src[k*REG_ID_W +: REG_ID_W]))
          fwd_sel_d[k*2 +: 2] = FWD_WB;
        else
          fwd_sel_d[k*2 +: 2] = FWD_REG;
      end
    end
  end
  assign bus.fwd_sel = fwd_sel_d;

  assign unused_sb = ^{sb[SB_MEM].is_load, sb[SB_WB].is_load};

  assign wait_d    = freeze ? sat_inc16(wait_q) : 16'd0;
  assign timeout_d = timeout_q | (freeze & (wait_d >= 16'(MEM_TIMEOUT)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.mem_timeout = timeout_q;

`ifdef HAZ_PERF_EN
  logic [15:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (loaduse_act)  stall_q  <= sat_inc16(stall_q);
      if (redirect_act) flush_q  <= sat_inc16(flush_q);
      if (freeze)       freeze_q <= sat_inc16(freeze_q);
    end
  end

  assign bus.stall_cycles  = stall_q;
  assign bus.flush_cycles  = flush_q;
  assign bus.freeze_cycles = freeze_q;
`else
  assign bus.stall_cycles  = 16'd0;
  assign bus.flush_cycles  = 16'd0;
  assign bus.freeze_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=3); perf checks follow HAZ_PERF_EN.
module tb_pipe_hazard_ctrl;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  pipe_hazard_ctrl_if #(.REG_ID_W(4), .NUM_SRC(2)) bus ();

  pipe_hazard_ctrl #(.REG_ID_W(4), .NUM_SRC(2), .MEM_TIMEOUT(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid    = 1'b0;
    bus.id_src_id   = 8'h00;
    bus.id_src_used = 2'b00;
    bus.id_dst_id   = 4'h0;
    bus.id_dst_wr   = 1'b0;
    bus.id_is_load  = 1'b0;
    bus.redirect    = 1'b0;
  endtask

  task automatic issue(input logic [3:0] src0, input logic [3:0] src1, input logic [1:0] used,
                       input logic [3:0] dst, input logic wr, input logic ld);
    bus.id_valid    = 1'b1;
    bus.id_src_id   = {src1, src0};
    bus.id_src_used = used;
    bus.id_dst_id   = dst;
    bus.id_dst_wr   = wr;
    bus.id_is_load  = ld;
  endtask

  task automatic flush_pipe();
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.pipe_en !== 1'b1) begin n_fail++; $display("FAIL reset_pipe_en got=%b exp=1", bus.pipe_en); end
    n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write got=%b exp=1", bus.pc_write); end
    n_checks++; if (bus.ifid_write !== 1'b1) begin n_fail++; $display("FAIL reset_ifid_write got=%b exp=1", bus.ifid_write); end
    n_checks++; if (bus.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL reset_ifid_flush got=%b exp=0", bus.ifid_flush); end
    n_checks++; if (bus.idex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_idex_bubble got=%b exp=0", bus.idex_bubble); end
    n_checks++; if (bus.fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd_sel got=%b exp=0000", bus.fwd_sel); end
    n_checks++; if (bus.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_mem_timeout got=%b exp=0", bus.mem_timeout); end
    n_checks++; if ({bus.stall_cycles, bus.flush_cycles, bus.freeze_cycles} !== 48'd0) begin
      n_fail++; $display("FAIL reset_perf got=%h/%h/%h exp=0", bus.stall_cycles, bus.flush_cycles, bus.freeze_cycles);
    end
    repeat (3) tick();
    n_checks++; if ({bus.pipe_en, bus.pc_write, bus.fwd_sel, bus.mem_timeout} !== 7'b1100000) begin
      n_fail++; $display("FAIL idle_outputs got=%b exp=1100000", {bus.pipe_en, bus.pc_write, bus.fwd_sel, bus.mem_timeout});
    end
  endtask

  task automatic test_load_use();
    logic [15:0] stall_before;
    stall_before = bus.stall_cycles;
    issue(4'h0, 4'h0, 2'b00, 4'h3, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_pre_pc_write got=%b exp=1", bus.pc_write); end
    tick();
    issue(4'h3, 4'h0, 2'b01, 4'h7, 1'b1, 1'b0);
    #1;
    n_checks++; if ({bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.ifid_flush} !== 4'b0010) begin
      n_fail++; $display("FAIL lu_stall got=%b exp=0010", {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.ifid_flush});
    end
    tick();
    #1;
    n_checks++; if ({bus.pc_write, bus.ifid_write, bus.idex_bubble} !== 3'b110) begin
      n_fail++; $display("FAIL lu_release got=%b exp=110", {bus.pc_write, bus.ifid_write, bus.idex_bubble});
    end
    tick();
    set_idle();
    #1;
    n_checks++; if (bus.fwd_sel[1:0] !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_wb got=%b exp=10", bus.fwd_sel[1:0]); end
`ifdef HAZ_PERF_EN
    n_checks++; if (bus.stall_cycles !== stall_before + 16'd1) begin
      n_fail++; $display("FAIL lu_stall_count got=%0d exp=%0d", bus.stall_cycles, stall_before + 16'd1);
    end
`else
    n_checks++; if (bus.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL lu_stall_count got=%0d exp=0", bus.stall_cycles); end
`endif
    flush_pipe();
  endtask

  task automatic test_forward();
    // ALU R2 then reader op1=R2 (op0 also names R2 but is unused)
    issue(4'h0, 4'h0, 2'b00, 4'h2, 1'b1, 1'b0);
    tick();
    issue(4'h2, 4'h2, 2'b10, 4'h9, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.idex_bubble !== 1'b0) begin n_fail++; $display("FAIL fwd_alu_no_stall got=%b exp=0", bus.idex_bubble); end
    tick();
    set_idle();
    #1;
    n_checks++; if (bus.fwd_sel !== 4'b0100) begin n_fail++; $display("FAIL fwd_mem got=%b exp=0100", bus.fwd_sel); end
    flush_pipe();

    issue(4'h0, 4'h0, 2'b00, 4'h2, 1'b1, 1'b0);
    tick();
    issue(4'h1, 4'h1, 2'b11, 4'h5, 1'b1, 1'b0);
    tick();
    issue(4'h0, 4'h2, 2'b10, 4'h9, 1'b0, 1'b0);
    tick();
    set_idle();
    #1;
    n_checks++; if (bus.fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL fwd_wb got=%b exp=1000", bus.fwd_sel); end
    flush_pipe();

    issue(4'h0, 4'h0, 2'b00, 4'h2, 1'b1, 1'b0);
    tick();
    issue(4'h0, 4'h0, 2'b00, 4'h2, 1'b1, 1'b0);
    tick();
    issue(4'h2, 4'h2, 2'b11, 4'h9, 1'b0, 1'b0);
    tick();
    set_idle();
    #1;
    n_checks++; if (bus.fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL fwd_mem_wins got=%b exp=0101", bus.fwd_sel); end
    flush_pipe();
  endtask

  task automatic test_redirect();
    logic [15:0] flush_before, stall_before;
    issue(4'h0, 4'h0, 2'b00, 4'h5, 1'b1, 1'b1);
    tick();
    issue(4'h5, 4'h0, 2'b01, 4'h6, 1'b1, 1'b0);
    bus.redirect = 1'b1;
    flush_before = bus.flush_cycles;
    stall_before = bus.stall_cycles;
    #1;
    n_checks++; if ({bus.ifid_flush, bus.idex_bubble, bus.pc_write, bus.ifid_write} !== 4'b1111) begin
      n_fail++; $display("FAIL redir_strobes got=%b exp=1111", {bus.ifid_flush, bus.idex_bubble, bus.pc_write, bus.ifid_write});
    end
    tick();
    set_idle();
    #1;
`ifdef HAZ_PERF_EN
    n_checks++; if (bus.flush_cycles !== flush_before + 16'd1) begin
      n_fail++; $display("FAIL redir_flush_count got=%0d exp=%0d", bus.flush_cycles, flush_before + 16'd1);
    end
    n_checks++; if (bus.stall_cycles !== stall_before) begin
      n_fail++; $display("FAIL redir_stall_count got=%0d exp=%0d", bus.stall_cycles, stall_before);
    end
`else
    n_checks++; if ({bus.flush_cycles, bus.stall_cycles} !== 32'd0) begin
      n_fail++; $display("FAIL redir_counts got=%0d/%0d exp=0/0", bus.flush_cycles, bus.stall_cycles);
    end
`endif
    flush_pipe();
  endtask

  task automatic test_freeze();
    logic [15:0] freeze_before;
    issue(4'h0, 4'h0, 2'b00, 4'h4, 1'b1, 1'b0);
    tick();
    issue(4'h4, 4'h0, 2'b01, 4'h8, 1'b0, 1'b0);
    tick();
    issue(4'h0, 4'h0, 2'b00, 4'h6, 1'b1, 1'b0);
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    freeze_before = bus.freeze_cycles;
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_checks++; if ({bus.pipe_en, bus.pc_write, bus.idex_bubble, bus.fwd_sel[1:0]} !== 5'b00001) begin
        n_fail++; $display("FAIL frz_hold cyc=%0d got=%b exp=00001", i, {bus.pipe_en, bus.pc_write, bus.idex_bubble, bus.fwd_sel[1:0]});
      end
      tick();
      n_checks++; if (bus.mem_timeout !== (i >= 3)) begin
        n_fail++; $display("FAIL frz_timeout cyc=%0d got=%b exp=%b", i, bus.mem_timeout, (i >= 3));
      end
    end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++; if (bus.pipe_en !== 1'b1) begin n_fail++; $display("FAIL frz_release got=%b exp=1", bus.pipe_en); end
    tick();
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    set_idle();
    #1;
    n_checks++; if (bus.mem_timeout !== 1'b1) begin n_fail++; $display("FAIL frz_sticky got=%b exp=1", bus.mem_timeout); end
`ifdef HAZ_PERF_EN
    n_checks++; if (bus.freeze_cycles !== freeze_before + 16'd5) begin
      n_fail++; $display("FAIL frz_count got=%0d exp=%0d", bus.freeze_cycles, freeze_before + 16'd5);
    end
`else
    n_checks++; if (bus.freeze_cycles !== 16'd0) begin n_fail++; $display("FAIL frz_count got=%0d exp=0", bus.freeze_cycles); end
`endif
    flush_pipe();
  endtask

  task automatic test_reset_mid_freeze();
    issue(4'h0, 4'h0, 2'b00, 4'h4, 1'b1, 1'b0);
    tick();
    issue(4'h4, 4'h0, 2'b01, 4'h8, 1'b0, 1'b0);
    tick();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.fwd_sel[1:0] !== 2'b01) begin n_fail++; $display("FAIL rst_pre_fwd got=%b exp=01", bus.fwd_sel[1:0]); end
    #2;
    RST = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    n_checks++; if ({bus.pipe_en, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.fwd_sel, bus.mem_timeout} !== 10'b1110000000) begin
      n_fail++; $display("FAIL rst_outputs got=%b exp=1110000000",
        {bus.pipe_en, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.fwd_sel, bus.mem_timeout});
    end
    n_checks++; if ({bus.stall_cycles, bus.flush_cycles, bus.freeze_cycles} !== 48'd0) begin
      n_fail++; $display("FAIL rst_perf got=%h/%h/%h exp=0", bus.stall_cycles, bus.flush_cycles, bus.freeze_cycles);
    end
    #1;
    RST = 1'b1;
    tick();
    n_checks++; if (bus.fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rst_sb_empty got=%b exp=0000", bus.fwd_sel); end
    set_idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b0;
    set_idle();
    bus.mem_req   = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b1;
    test_reset();
    test_load_use();
    test_forward();
    test_redirect();
    test_freeze();
    test_reset_mid_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Holds its own destination scoreboard for EX/MEM/WB and latches the EX-stage source IDs. It then generates PC/IF-ID enables, bubble/flush strobes and per-operand forward selects.
- Adds a global pipeline freeze for multi-cycle memory (mem_req/mem_ready handshake) with a wait-state timeout.
- Replaces the separate load-use detector and forward unit in the CPU top level.

Parameters:
REG_ID_W, 4, register ID width (8 GPRs plus special registers T/SP/IH/RA).
NUM_SRC, 2, source operands per instruction.
MEM_TIMEOUT, 255, maximum consecutive freeze cycles before mem_timeout is flagged (1..65535).

Ports:
CLK  in  1  CPU clock (pipeline advance edge).
RST  in  1  asynchronous, active-low reset.
id_valid  in  1  ID-stage instruction valid (0 for bubble/NOP).
id_src_id  in  NUM_SRC*REG_ID_W  ID source register IDs; operand k at [k*REG_ID_W +: REG_ID_W].
id_src_used  in  NUM_SRC  bit k: operand k is actually read.
id_dst_id  in  REG_ID_W  ID destination register ID.
id_dst_wr  in  1  ID instruction writes a register.
id_is_load  in  1  ID instruction is a memory load.
redirect  in  1  taken branch/jump resolved in EX.
mem_req  in  1  MEM stage has an active access.
mem_ready  in  1  memory/UART access completes this cycle.
pipe_en  out  1  global advance enable for all pipeline registers.
pc_write  out  1  PC load enable.
ifid_write  out  1  IF/ID load enable.
ifid_flush  out  1  load NOP into IF/ID.
idex_bubble  out  1  load bubble (regWrite=0, memWrite=0) into ID/EX.
fwd_sel  out  NUM_SRC*2  per EX operand: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
mem_timeout  out  1  sticky wait-state timeout flag.
stall_cycles, flush_cycles, freeze_cycles  out  16 each  performance counters.

Behaviour:
- Scoreboard: entries sb[0]=EX, sb[1]=MEM, sb[2]=WB, each {valid, wr, dst, is_load}. ex_src[k] and ex_used[k] are latched from ID.
- Advance (posedge CLK with pipe_en=1): sb[2]<=sb[1]; sb[1]<=sb[0]; sb[0]<=ID entry. sb[0] instead gets an invalid entry when idex_bubble=1. ex_src/ex_used follow sb[0], cleared on a bubble.
- freeze = mem_req & ~mem_ready.
- pipe_en = ~freeze. When pipe_en=0, all registers hold and all strobes are 0.
- loaduse = id_valid & sb[0].valid & sb[0].wr & sb[0].is_load & (any k: id_src_used[k] & id_src_id[k]==sb[0].dst).
- Priority: freeze > redirect > loaduse.
  - redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
  - loaduse: pc_write=0, ifid_write=0, idex_bubble=1; cleared after one advance.
  - none: pc_write=ifid_write=1, strobes 0.
- fwd_sel[k] (combinational):
  - 00 if ~ex_used[k].
  - Else 01 if sb[1] valid, wr and dst==ex_src[k].
  - Else 10 if the same holds on sb[2].
  - Else 00. MEM match takes precedence over WB.
- There is no zero-register exception; every ID is a real register.
- Timeout:
  - A 16-bit wait counter increments each freeze cycle and clears when freeze=0.
  - When it reaches MEM_TIMEOUT, mem_timeout<=1 and stays set until reset.
  - Freeze continues regardless; the flag is diagnostic only.
- Reset (async, RST=0): all sb/ex_src invalid or 0, wait counter 0, mem_timeout 0, perf counters 0.
- Outputs after reset: pipe_en=1, pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_sel=0.
- Reset asserted mid-freeze or mid-stall clears state immediately; there is no replay.
- Latency: all control outputs are combinational from the current inputs and scoreboard; the scoreboard has 1-cycle update.

Optional Feature:
HAZ_PERF_EN.
- Defined:
  - stall_cycles counts loaduse cycles (not frozen, no redirect).
  - flush_cycles counts redirect cycles (not frozen).
  - freeze_cycles counts freeze cycles.
  - All are 16-bit, saturating at 16'hFFFF and reset to 0.
- Undefined: the three ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package pipe_pkg: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10 constants; sb_entry_t struct {valid, wr, dst, is_load}; SB_EX=0, SB_MEM=1, SB_WB=2 indices.
- Sub-module hazard_scoreboard: the 3-entry shift register plus ex_src latch, with advance/bubble inputs.
- Hazard/forward logic, timeout and perf counters stay in pipe_hazard_ctrl.

Test Plan:
- Reset, then idle with id_valid=0 -> pipe_en=1, pc_write=1, fwd_sel=0, mem_timeout=0.
- Load writes R3, next instruction reads R3 (op0) -> one cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle no stall; the consumer in EX then sees fwd_sel[1:0]=10 (load in WB).
- ALU writes R2, immediately followed by reader of R2 on op1 -> fwd_sel[3:2]=01. Same reader one instruction later -> fwd_sel[3:2]=10. Both R2 writers in flight -> 01 wins.
- redirect=1 coincident with loaduse -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cycles +1 and stall_cycles unchanged (HAZ_PERF_EN).
- mem_req=1, mem_ready=0 for 5 cycles with MEM_TIMEOUT=3 -> pipe_en=0 for 5 cycles, scoreboard unchanged, mem_timeout rises after the 3rd freeze cycle and stays 1 after mem_ready=1.
- RST pulsed low during a freeze -> all outputs return to reset values immediately; scoreboard empty (no forwarding next cycle).
